// File: rtl/satatrn_pkg.sv
// Shared constants and CRC helper for the SATA transport TX path.
package satatrn_pkg;

  localparam logic [31:0] SATA_CRC_INIT  = 32'h5232_5032;
  localparam logic [31:0] SATA_CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [15:0] SCRAMBLER_SEED = 16'hFFFF;

  typedef enum logic {
    ST_DATA,
    ST_CRC
  } txcrc_state_t;

  // One dword folded in MSB first, no reflection.
  function automatic logic [31:0] crc_next(
    input logic [31:0] crc,
    input logic [31:0] dw
  );
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ dw[i];
      c  = {c[30:0], 1'b0} ^ (fb ? SATA_CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/satatrn_scrambler.sv
// SATA scrambler: 16-bit LFSR x^16+x^15+x^13+x^4+1, 32 bits per advance.
module satatrn_scrambler
  import satatrn_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        reseed,
  input  logic        advance,
  output logic [31:0] mask
);

  localparam logic [15:0] TAPS = 16'hA011;

  logic [15:0] lfsr;
  logic [15:0] walk;

  // First bit out lands in mask[0].
  always_comb begin
    walk = reseed ? SCRAMBLER_SEED : lfsr;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      mask[i] = walk[15];
      walk    = {walk[14:0], 1'b0} ^ (walk[15] ? TAPS : 16'h0);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lfsr <= SCRAMBLER_SEED;
    end else if (advance) begin
      lfsr <= walk;
    end
  end

endmodule

// File: rtl/satatrn_txcrc.sv
// FIS dword pass-through that appends the SATA CRC dword to each frame.
// Optional scrambling of data and CRC under SATATRN_TXCRC_SCRAMBLE_EN.
module satatrn_txcrc
  import satatrn_pkg::*;
#(
  parameter logic OPT_LOWPOWER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);

  txcrc_state_t state, state_nxt;

  logic [31:0] crc, crc_nxt;
  logic        can_load, take;
  logic        load, load_last;
  logic [31:0] load_word, mask;
  logic        vld_nxt, lst_nxt;
  logic [31:0] dat_nxt;

  assign can_load = !m_valid || m_ready;
  assign s_ready  = (state == ST_DATA) && can_load;
  assign take     = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    load      = 1'b0;
    load_last = 1'b0;
    load_word = s_data;
    unique case (state)
      ST_DATA: begin
        if (take) begin
          load    = 1'b1;
          crc_nxt = crc_next(crc, s_data);
          if (s_last) state_nxt = ST_CRC;
        end
      end
      ST_CRC: begin
        if (can_load) begin
          load      = 1'b1;
          load_last = 1'b1;
          load_word = crc;
          crc_nxt   = SATA_CRC_INIT;
          state_nxt = ST_DATA;
        end
      end
    endcase
  end

  always_comb begin
    vld_nxt = m_valid;
    dat_nxt = m_data;
    lst_nxt = m_last;
    if (load) begin
      vld_nxt = 1'b1;
      dat_nxt = load_word ^ mask;
      lst_nxt = load_last;
    end else if (can_load) begin
      vld_nxt = 1'b0;
      if (OPT_LOWPOWER) begin
        dat_nxt = '0;
        lst_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_DATA;
      crc     <= SATA_CRC_INIT;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      crc     <= crc_nxt;
      m_valid <= vld_nxt;
      m_data  <= dat_nxt;
      m_last  <= lst_nxt;
    end
  end

`ifdef SATATRN_TXCRC_SCRAMBLE_EN
  // Set until the first dword of a frame is loaded.
  logic sof;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sof <= 1'b1;
    end else if (load) begin
      sof <= load_last;
    end
  end

  satatrn_scrambler u_scr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .reseed  (sof),
    .advance (load),
    .mask    (mask)
  );
`else
  assign mask = '0;
`endif

endmodule

// File: tb/tb_satatrn_txcrc.sv
// Randomized scoreboard bench for satatrn_txcrc plus directed frames.
module tb_satatrn_txcrc;

  localparam logic [31:0] CRC_INIT = 32'h5232_5032;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } item_t;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data  = '0;
  logic        s_last  = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  item_t       tx_q[$];
  item_t       cap_q[$];
  item_t       exp_q[$];
  logic [31:0] frame_w[$];
  int          run_cur = 0;
  int          run_max = 0;

  satatrn_txcrc dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // CRC over a whole frame as one bit stream, MSB of each dword first.
  function automatic logic [31:0] crc_of(input logic [31:0] init,
                                         input logic [31:0] w[$]);
    logic [31:0] r;
    logic        b;
    r = init;
    foreach (w[j]) begin
      for (int i = 31; i >= 0; i--) begin
        b = r[31] ^ w[j][i];
        r = (r << 1) ^ (b ? CRC_POLY : 32'h0);
      end
    end
    return r;
  endfunction

  // k-th mask dword of a frame (0 = first data dword).
  function automatic logic [31:0] scr_mask(input int k);
    logic [31:0] mk;
`ifdef SATATRN_TXCRC_SCRAMBLE_EN
    logic [15:0] st;
    logic        b;
    st = 16'hFFFF;
    mk = '0;
    for (int n = 0; n < (k + 1) * 32; n++) begin
      b  = st[15];
      st = (st << 1) ^ (b ? 16'hA011 : 16'h0);
      if (n >= k * 32) mk[n - k * 32] = b;
    end
`else
    mk = 32'(k) & 32'h0;
`endif
    return mk;
  endfunction

  // Scoreboard / protocol model, one evaluation per cycle.
  logic  exp_v = 1'b0;
  logic  pending = 1'b0;
  logic  stall = 1'b0;
  logic  can, exp_rdy, acc, crc_ld;
  item_t held, it;

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        chk("reset_m_valid", 32'(m_valid), 32'h0);
        chk("reset_m_data", m_data, 32'h0);
        chk("reset_m_last", 32'(m_last), 32'h0);
        exp_q.delete();
        frame_w.delete();
        exp_v   = 1'b0;
        pending = 1'b0;
        stall   = 1'b0;
      end else begin
        can     = !exp_v || m_ready;
        exp_rdy = !pending && can;
        crc_ld  = pending && can;
        chk("m_valid", 32'(m_valid), 32'(exp_v));
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        if (stall) begin
          chk("hold_data", m_data, held.data);
          chk("hold_last", 32'(m_last), 32'(held.last));
        end
        if (exp_v && m_ready) begin
          chk("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("m_data", m_data, it.data);
            chk("m_last", 32'(m_last), 32'(it.last));
          end
        end
        acc = s_valid && exp_rdy;
        if (acc) begin
          exp_q.push_back('{s_data ^ scr_mask(frame_w.size()), 1'b0});
          frame_w.push_back(s_data);
          if (s_last) begin
            exp_q.push_back('{crc_of(CRC_INIT, frame_w)
                              ^ scr_mask(frame_w.size()), 1'b1});
            frame_w.delete();
          end
        end
        stall = exp_v && !m_ready;
        held  = '{m_data, m_last};
        exp_v = acc || crc_ld || stall;
        if (crc_ld) pending = 1'b0;
        else if (acc && s_last) pending = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    if (m_valid && m_ready) cap_q.push_back('{m_data, m_last});
    run_cur = m_valid ? run_cur + 1 : 0;
    if (run_cur > run_max) run_max = run_cur;
  endtask

  task automatic tick();
    @(negedge i_clk);
    sample();
  endtask

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return ~m_ready;
    return $urandom_range(9) < 7;
  endfunction

  task automatic push_word(input logic [31:0] d, input logic l);
    tx_q.push_back('{d, l});
  endtask

  // mode 1: m_ready high, 2: m_ready toggles, 3: random both sides
  task automatic send(input int n_stop, input int mode);
    int nacc;
    int guard;
    nacc  = 0;
    guard = 0;
    while (tx_q.size() > 0 && nacc != n_stop && guard < 3000) begin
      step();
      s_valid = (mode == 3) ? ($urandom_range(3) != 0) : 1'b1;
      s_data  = tx_q[0].data;
      s_last  = tx_q[0].last;
      m_ready = pick(mode);
      tick();
      if (s_valid && s_ready) begin
        void'(tx_q.pop_front());
        nacc++;
      end
      guard++;
    end
    chk("send_bounded", 32'(guard < 3000), 32'h1);
  endtask

  task automatic drain(input int mode);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 2; i++) begin
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = pick(mode);
      tick();
      quiet = m_valid ? 0 : quiet + 1;
    end
    chk("drain_bounded", 32'(quiet >= 2), 32'h1);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  logic [31:0] q[$];
  logic [31:0] a0, a1, w0, c1;

  initial begin
    q = {32'h0000_0001};
    chk("pin_crc_poly", crc_of(32'h0, q), 32'h04C1_1DB7);
    q = {32'h5232_5032};
    chk("pin_crc_zero", crc_of(CRC_INIT, q), 32'h0);
`ifdef SATATRN_TXCRC_SCRAMBLE_EN
    chk("pin_scr_first", scr_mask(0), 32'hC2D2_768D);
`endif

    // reset held with s_valid high
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    s_last  = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    step();
    i_reset = 1'b0;
    tick();
    chk("rel_m_valid", 32'(m_valid), 32'h0);
    chk("rel_m_data", m_data, 32'h0);
    chk("rel_s_ready", 32'(s_ready), 32'h1);
    drain(1);

    // single-dword FIS
    q = {32'h0000_0046};
    c1 = crc_of(CRC_INIT, q);
    cap_q.delete();
    step();
    s_valid = 1'b1;
    s_data  = 32'h0000_0046;
    s_last  = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("one_accept", 32'(s_ready), 32'h1);
    step();
    s_valid = 1'b0;
    tick();
    chk("one_data", m_data, 32'h0000_0046 ^ scr_mask(0));
    chk("one_data_last", 32'(m_last), 32'h0);
    chk("one_crc_cycle_ready", 32'(s_ready), 32'h0);
    step();
    tick();
    chk("one_crc", m_data, c1 ^ scr_mask(1));
    chk("one_crc_last", 32'(m_last), 32'h1);
    drain(1);
    chk("one_count", 32'(cap_q.size()), 32'h2);

    // 3-dword FIS with toggling m_ready
    cap_q.delete();
    push_word(32'h0000_0027, 1'b0);
    push_word(32'h1234_5678, 1'b0);
    push_word(32'hDEAD_BEEF, 1'b1);
    q = {32'h0000_0027, 32'h1234_5678, 32'hDEAD_BEEF};
    send(-1, 2);
    drain(2);
    chk("three_count", 32'(cap_q.size()), 32'h4);
    chk("three_d0", cap_q[0].data, 32'h0000_0027 ^ scr_mask(0));
    chk("three_d1", cap_q[1].data, 32'h1234_5678 ^ scr_mask(1));
    chk("three_d2", cap_q[2].data, 32'hDEAD_BEEF ^ scr_mask(2));
    chk("three_crc", cap_q[3].data, crc_of(CRC_INIT, q) ^ scr_mask(3));
    chk("three_lasts", {28'h0, cap_q[0].last, cap_q[1].last,
                        cap_q[2].last, cap_q[3].last}, 32'h1);

    // two identical 2-dword frames back-to-back
    a0 = $urandom;
    a1 = $urandom;
    cap_q.delete();
    run_cur = 0;
    run_max = 0;
    repeat (2) begin
      push_word(a0, 1'b0);
      push_word(a1, 1'b1);
    end
    send(-1, 1);
    drain(1);
    q = {a0, a1};
    chk("b2b_run", 32'(run_max), 32'h6);
    chk("b2b_count", 32'(cap_q.size()), 32'h6);
    chk("b2b_reinit", cap_q[5].data, cap_q[2].data);
    chk("b2b_crc2", cap_q[5].data, crc_of(CRC_INIT, q) ^ scr_mask(2));

    // zero first dword exposes the scrambler mask
    cap_q.delete();
    push_word(32'h0, 1'b0);
    push_word(32'h5232_5032, 1'b1);
    send(-1, 1);
    drain(1);
`ifdef SATATRN_TXCRC_SCRAMBLE_EN
    chk("zero_first", cap_q[0].data, 32'hC2D2_768D);
`else
    chk("zero_first", cap_q[0].data, 32'h0);
`endif

    // CRC of a frame equal to the init value is zero
    cap_q.delete();
    push_word(32'h5232_5032, 1'b1);
    send(-1, 1);
    drain(1);
    chk("init_frame_crc", cap_q[1].data, scr_mask(1));

    // reset after 2 of 5 dwords, then a fresh 1-dword frame
    for (int i = 0; i < 5; i++) push_word($urandom, i == 4);
    send(2, 1);
    step();
    i_reset = 1'b1;
    s_valid = 1'b0;
    tick();
    step();
    tick();
    step();
    i_reset = 1'b0;
    tx_q.delete();
    cap_q.delete();
    w0 = $urandom;
    push_word(w0, 1'b1);
    send(-1, 1);
    drain(1);
    q = {w0};
    chk("rst_count", 32'(cap_q.size()), 32'h2);
    chk("rst_crc", cap_q[1].data, crc_of(CRC_INIT, q) ^ scr_mask(1));

    // randomized frames, random valid/ready on both sides
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) push_word($urandom, i == len - 1);
    end
    send(-1, 3);
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
